flat_stim_seq: RTL and testbench
================================

Name: flat_stim_seq

Overview:
Upstream stimulus sequencer for the flattened test-library wrappers. It generates input vectors onto a packed `in_flat` bus that connects directly to a wrapper's `in_flat` port. Vectors come from either an exhaustive sweep or a Fibonacci LFSR, delivered under a valid/ready handshake. A start/done pair lets the fuzz harness run one vector campaign per start.

Parameters:
IN_W, 4, width of `in_flat`; matches the downstream wrapper's flattened input width
TAPS, 4'b1100, LFSR feedback mask; bit i set means `in_flat[i]` is XORed into feedback; default gives x^4+x^3+1, period 15
NUM_VEC, 16, vectors per campaign in LFSR mode; legal range 1 to 2^IN_W
CNT_W, IN_W+1, width of `vec_count`

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  campaign request; sampled only in IDLE
mode  in  1  0 = exhaustive sweep, 1 = LFSR; sampled together with start
seed  in  IN_W  LFSR seed; sampled together with start
in_flat  out  IN_W  current vector to the downstream wrapper
out_valid  out  1  `in_flat` holds a valid vector
out_ready  in  1  downstream accepts the vector
busy  out  1  campaign in progress
done  out  1  one-cycle pulse at campaign end
vec_count  out  CNT_W  number of vectors accepted in the current or last campaign

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; `in_flat`=0, `out_valid`=0, `busy`=0, `done`=0, `vec_count`=0. Reset mid-campaign aborts immediately, with no done pulse.
- All outputs are registered. States are IDLE, RUN, DONE.
- IDLE:
  - On `start`=1 at a clock edge, go to RUN.
  - Load `in_flat`: 0 if `mode`=0; `seed` if `mode`=1, with `seed`=0 replaced by 1 (the LFSR must never lock at zero).
  - Set `out_valid`=1 and `busy`=1, and clear `vec_count`=0.
  - Result: first vector visible the cycle after `start`.
- RUN:
  - Transfer occurs at a rising edge with `out_valid` and `out_ready` both 1. On each transfer, `vec_count` increments by 1.
  - While `out_valid`=1 and `out_ready`=0, `in_flat` and `out_valid` hold stable. No vector is skipped or altered.
  - Last-vector test:
    - Sweep mode: the transfer with `in_flat` all-ones, giving 2^IN_W vectors.
    - LFSR mode: the transfer with `vec_count`==NUM_VEC-1 before increment.
  - On a non-last transfer: the next vector is loaded in the same edge and `out_valid` stays 1. This gives back-to-back throughput of one vector per cycle.
    - Sweep next = `in_flat`+1.
    - LFSR next = {`in_flat`[IN_W-2:0], fb}, where fb = XOR-reduce(`in_flat` & TAPS).
  - On the last transfer: `out_valid`=0, go to DONE. `in_flat` keeps the last vector.
- DONE: `done`=1 for exactly one cycle, `busy`=0 in the same cycle, then go to IDLE.
- `busy` is 1 from the cycle after start up to and including the last-transfer cycle.
- `vec_count` holds its final value until the next accepted `start`.
- `start` is ignored while in RUN or DONE. `mode` and `seed` changes during RUN have no effect.
- `start` held high continuously: a new campaign begins on the first IDLE cycle after DONE.
- LFSR mode with NUM_VEC larger than the LFSR period: the sequence repeats. This is legal and not flagged.

Test Plan:
1. Full sweep: mode=0, `out_ready`=1 constant, one-cycle `start` pulse.
   -> `in_flat` = 0,1,...,15 on 16 consecutive cycles with `out_valid`=1.
   -> `done` pulses on the following cycle.
   -> `vec_count`=16, `busy` falls with `done`.
2. Backpressure: sweep mode; drive `out_ready`=0 for 3 cycles while `in_flat`=4'h5.
   -> `in_flat` stays 4'h5 and `out_valid` stays 1 for those cycles.
   -> The next accepted value is 4'h6, and the total accepted is still 16.
3. LFSR: mode=1, seed=4'h1, NUM_VEC=6, `out_ready`=1.
   -> Vectors 1,2,4,9,3,6; then `done`; `vec_count`=6.
4. Zero seed: mode=1, seed=0.
   -> First vector is 4'h1, and the sequence matches test 3.
5. Start while busy: pulse `start` again at vector 4 of a sweep.
   -> No restart, sweep completes normally, exactly one `done` pulse.
6. Reset mid-run: assert `rst_n`=0 at vector 7.
   -> All outputs 0 asynchronously, with no `done`.
   -> After release, a new `start` produces vector 0 and `vec_count` restarts at 0.

Source files
------------

// File: rtl/flat_stim_seq.sv
// Stimulus sequencer driving a flattened wrapper input bus with sweep or LFSR vectors.
// One campaign per accepted start, delivered under a valid/ready handshake.
module flat_stim_seq #(
   parameter int          IN_W    = 4,
   parameter logic [IN_W-1:0] TAPS = 4'b1100,
   parameter int          NUM_VEC = 16,
   parameter int          CNT_W   = IN_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [IN_W-1:0]  seed,
   output logic [IN_W-1:0]  in_flat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [IN_W-1:0]  VEC_ONE  = {{(IN_W-1){1'b0}}, 1'b1};
   localparam logic [IN_W-1:0]  VEC_ZERO = {IN_W{1'b0}};

   // Fibonacci step: shift left, feedback is the parity of the tapped bits.
   function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
      return {v[IN_W-2:0], ^(v & TAPS)};
   endfunction

   // A zero seed would lock the LFSR, so it is promoted to one.
   function automatic logic [IN_W-1:0] seed_fix(input logic [IN_W-1:0] s);
      return (s == VEC_ZERO) ? VEC_ONE : s;
   endfunction

   state_t           r_state;
   logic [IN_W-1:0]  r_in_flat;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_mode;
   logic [CNT_W-1:0] r_vec_count;

   logic             w_xfer;
   logic             w_last;
   logic [IN_W-1:0]  w_next;

   assign w_xfer = r_valid & out_ready;
   assign w_last = r_mode ? (r_vec_count == LAST_CNT) : (&r_in_flat);
   assign w_next = r_mode ? lfsr_step(r_in_flat) : (r_in_flat + VEC_ONE);

   // Campaign FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_flat   <= VEC_ZERO;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mode      <= 1'b0;
         r_vec_count <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state     <= S_RUN;
                  r_mode      <= mode;
                  r_in_flat   <= mode ? seed_fix(seed) : VEC_ZERO;
                  r_valid     <= 1'b1;
                  r_busy      <= 1'b1;
                  r_vec_count <= {CNT_W{1'b0}};
               end
            end
            S_RUN: begin
               if (w_xfer) begin
                  r_vec_count <= r_vec_count + CNT_ONE;
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_in_flat <= w_next;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign in_flat   = r_in_flat;
   assign out_valid = r_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign vec_count = r_vec_count;

endmodule

// File: tb/tb_flat_stim_seq.sv
// Directed bench for flat_stim_seq: vector table for sweep/LFSR campaigns plus
// hand-written sequences for backpressure, zero seed, start while busy and reset.
module tb_flat_stim_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic [3:0] seed;
   logic [3:0] in_flat;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic [4:0] vec_count;

   int total = 0;
   int bad   = 0;

   flat_stim_seq #(.IN_W(4), .TAPS(4'b1100), .NUM_VEC(6), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
      .in_flat(in_flat), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .vec_count(vec_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       md;
      logic [3:0] sd;
      logic       rdy;
      logic [3:0] e_in;
      logic       e_v;
      logic       e_b;
      logic       e_d;
      logic [4:0] e_c;
   } vec_t;

   vec_t tbl[$];
   logic [3:0] lf [6] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic m, input logic [3:0] sd, input logic r);
      start = s; mode = m; seed = sd; out_ready = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic st, input logic md, input logic [3:0] sd,
                               input logic rdy, input logic [3:0] e_in, input logic e_v,
                               input logic e_b, input logic e_d, input logic [4:0] e_c);
      vec_t v;
      v.st = st; v.md = md; v.sd = sd; v.rdy = rdy;
      v.e_in = e_in; v.e_v = e_v; v.e_b = e_b; v.e_d = e_d; v.e_c = e_c;
      return v;
   endfunction

   initial begin
      int n;
      int dones;
      logic seen;

      rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = 4'h0; out_ready = 1'b0;

      // full sweep: 0..15, then done with count 16, then idle
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 5'd0));
      for (int k = 1; k < 16; k++)
         tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 4'(k), 1'b1, 1'b1, 1'b0, 5'(k)));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 5'd16));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 5'd16));
      // LFSR seed 1, six vectors
      tbl.push_back(mk(1'b1, 1'b1, 4'h1, 1'b1, lf[0], 1'b1, 1'b1, 1'b0, 5'd0));
      for (int k = 1; k < 6; k++)
         tbl.push_back(mk(1'b0, 1'b1, 4'h1, 1'b1, lf[k], 1'b1, 1'b1, 1'b0, 5'(k)));
      tbl.push_back(mk(1'b0, 1'b0, 4'h7, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 5'd6));
      tbl.push_back(mk(1'b0, 1'b0, 4'h7, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 5'd6));

      @(negedge clk);
      chk("reset_outs", {in_flat, out_valid, busy, done, vec_count}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].st, tbl[i].md, tbl[i].sd, tbl[i].rdy);
         chk($sformatf("vec%0d", i), {in_flat, out_valid, busy, done, vec_count},
             {tbl[i].e_in, tbl[i].e_v, tbl[i].e_b, tbl[i].e_d, tbl[i].e_c});
      end

      // backpressure while in_flat is 5
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
      chk("bp_pre", {in_flat, vec_count}, {4'h5, 5'd5});
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b0, 4'h0, 1'b0);
         chk($sformatf("bp_hold%0d", k), {in_flat, out_valid, vec_count}, {4'h5, 1'b1, 5'd5});
      end
      cyc(1'b0, 1'b0, 4'h0, 1'b1);
      chk("bp_next", {in_flat, vec_count}, {4'h6, 5'd6});
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         cyc(1'b0, 1'b0, 4'h0, 1'b1);
         n++;
         seen = done;
      end
      chk("bp_done_cycles", n, 10);
      chk("bp_total", {done, vec_count}, {1'b1, 5'd16});
      cyc(1'b0, 1'b0, 4'h0, 1'b1);

      // zero seed behaves like seed 1
      cyc(1'b1, 1'b1, 4'h0, 1'b1);
      chk("zs_first", {in_flat, out_valid}, {lf[0], 1'b1});
      for (int k = 1; k < 6; k++) begin
         cyc(1'b0, 1'b1, 4'h0, 1'b1);
         chk($sformatf("zs%0d", k), in_flat, lf[k]);
      end
      cyc(1'b0, 1'b1, 4'h0, 1'b1);
      chk("zs_done", {done, busy, vec_count}, {1'b1, 1'b0, 5'd6});
      cyc(1'b0, 1'b0, 4'h0, 1'b1);

      // start pulse during a sweep is ignored
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
      cyc(1'b1, 1'b1, 4'h9, 1'b1);
      chk("sb_no_restart", {in_flat, vec_count}, {4'h4, 5'd4});
      dones = 0;
      for (int k = 0; k < 25; k++) begin
         cyc(1'b0, 1'b0, 4'h0, 1'b1);
         if (done) dones++;
      end
      chk("sb_one_done", dones, 1);
      chk("sb_end", {in_flat, busy, vec_count}, {4'hF, 1'b0, 5'd16});

      // asynchronous reset at vector 7
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
      for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
      chk("rst_pre", in_flat, 4'h7);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", {in_flat, out_valid, busy, done, vec_count}, 12'h000);
      cyc(1'b0, 1'b0, 4'h0, 1'b1);
      chk("rst_no_done", {done, busy}, 2'b00);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
      chk("rst_restart", {in_flat, out_valid, vec_count}, {4'h0, 1'b1, 5'd0});
      cyc(1'b0, 1'b0, 4'h0, 1'b1);
      chk("rst_second", {in_flat, vec_count}, {4'h1, 5'd1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
